param_up_down_counter: RTL and testbench

//  Parametrised up/down counter: configurable width and step, runtime bounds, wrap or saturate

---
 rtl/param_up_down_counter_if.sv | 38 +++
 rtl/param_up_down_counter.sv | 117 +++++++++++
 tb/tb_param_up_down_counter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_up_down_counter_if.sv
// Bus bundle for param_up_down_counter: control/bound inputs and count/status outputs.
// The snap/snap_count pair is only used when the counter is built with UDC_SNAPSHOT_EN.
interface param_up_down_counter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  data_in;
  logic              en;
  logic              up;
  logic              down;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  lo_bound;
  logic [WIDTH-1:0]  hi_bound;
  logic              sat_mode;
  logic              oneshot;
  logic [WIDTH-1:0]  count;
  logic              ovf;
  logic              unf;
  logic              at_hi;
  logic              at_lo;
  logic              busy;
  logic              snap;
  logic [WIDTH-1:0]  snap_count;

  modport master (
    output clear, load, data_in, en, up, down, step, lo_bound, hi_bound, sat_mode, oneshot,
           snap,
    input  count, ovf, unf, at_hi, at_lo, busy, snap_count
  );

  modport slave (
    input  clear, load, data_in, en, up, down, step, lo_bound, hi_bound, sat_mode, oneshot,
           snap,
    output count, ovf, unf, at_hi, at_lo, busy, snap_count
  );
endinterface

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with runtime bounds, wrap/saturate and one-shot modes.
// Optional count snapshot register enabled by defining UDC_SNAPSHOT_EN. STEP_W must be <= WIDTH.
module param_up_down_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                    clk,
  input logic                    reset,
  param_up_down_counter_if.slave bus
);

  typedef enum logic [0:0] {StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             up_hit;
  logic             down_hit;
  logic             count_act;

  // One extra bit so neither direction silently wraps mod 2^WIDTH.
  assign step_ext = (WIDTH+1)'(bus.step);
  assign sum      = {1'b0, count_q} + step_ext;
  assign diff     = {1'b0, count_q} - step_ext;
  assign up_hit   = sum > {1'b0, bus.hi_bound};
  // diff[WIDTH] set means the subtraction went negative.
  assign down_hit = diff[WIDTH] | (diff[WIDTH-1:0] < bus.lo_bound);

  assign count_act = bus.en && (state_q == StRun) && (bus.up ^ bus.down) &&
                     (bus.step != '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    state_d = state_q;
    if (bus.clear) begin
      count_d = RST_VAL;
      state_d = StRun;
    end else if (bus.load) begin
      state_d = StRun;
      if (bus.data_in < bus.lo_bound) begin
        count_d = bus.lo_bound;
      end else if (bus.data_in > bus.hi_bound) begin
        count_d = bus.hi_bound;
      end else begin
        count_d = bus.data_in;
      end
    end else if (count_act) begin
      if (bus.up) begin
        if (up_hit) begin
          ovf_d   = 1'b1;
          count_d = bus.sat_mode ? bus.hi_bound : bus.lo_bound;
          if (bus.oneshot) state_d = StDone;
        end else begin
          count_d = sum[WIDTH-1:0];
        end
      end else begin
        if (down_hit) begin
          unf_d   = 1'b1;
          count_d = bus.sat_mode ? bus.lo_bound : bus.hi_bound;
          if (bus.oneshot) state_d = StDone;
        end else begin
          count_d = diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      count_q <= RST_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.at_hi = (count_q == bus.hi_bound);
  assign bus.at_lo = (count_q == bus.lo_bound);
  assign bus.busy  = (state_q == StRun);

`ifdef UDC_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q;

  // Captures the pre-update count regardless of en or FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (bus.snap) begin
      snap_q <= count_q;
    end
  end

  assign bus.snap_count = snap_q;
`else
  logic unused_snap;

  assign unused_snap    = bus.snap;
  assign bus.snap_count = '0;
`endif

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench for param_up_down_counter (WIDTH=8, STEP_W=4, RST_VAL=0).
// Snapshot checks are compiled only when UDC_SNAPSHOT_EN is defined.
module tb_param_up_down_counter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  param_up_down_counter_if #(.WIDTH(8), .STEP_W(4)) bus ();

  param_up_down_counter #(
    .WIDTH  (8),
    .STEP_W (4),
    .RST_VAL(8'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the active edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.clear = 0; bus.load = 0; bus.data_in = 0; bus.en = 0; bus.up = 0; bus.down = 0;
    bus.step = 0; bus.lo_bound = 0; bus.hi_bound = 8'd255; bus.sat_mode = 0;
    bus.oneshot = 0; bus.snap = 0;
    #13;
    checks++; if (bus.count !== 8'd0) begin failures++;
      $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin failures++;
      $display("FAIL reset_flags got=%b%b exp=00", bus.ovf, bus.unf); end
    checks++; if (bus.busy !== 1'b1) begin failures++;
      $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.snap_count !== 8'd0) begin failures++;
      $display("FAIL reset_snap got=%0d exp=0", bus.snap_count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_up();
    bus.en = 1; bus.step = 4'd1; bus.lo_bound = 0; bus.hi_bound = 8'd255;
    checks++; if (bus.at_lo !== 1'b1) begin failures++;
      $display("FAIL up_at_lo_initial got=%b exp=1", bus.at_lo); end
    bus.up = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.count !== 8'(i)) begin failures++;
        $display("FAIL up_count step%0d got=%0d exp=%0d", i, bus.count, i); end
      checks++; if (bus.at_lo !== 1'b0) begin failures++;
        $display("FAIL up_at_lo step%0d got=%b exp=0", i, bus.at_lo); end
    end
    bus.up = 0;
  endtask

  task automatic test_wrap();
    bus.lo_bound = 8'd10; bus.hi_bound = 8'd20; bus.sat_mode = 0;
    do_load(8'd18);
    checks++; if (bus.count !== 8'd18) begin failures++;
      $display("FAIL wrap_load got=%0d exp=18", bus.count); end
    bus.step = 4'd3; bus.up = 1;
    tick();
    bus.up = 0;
    checks++; if (bus.count !== 8'd10 || bus.ovf !== 1'b1) begin failures++;
      $display("FAIL wrap_up got=%0d/ovf%b exp=10/ovf1", bus.count, bus.ovf); end
    tick();
    checks++; if (bus.count !== 8'd10 || bus.ovf !== 1'b0) begin failures++;
      $display("FAIL wrap_ovf_pulse got=%0d/ovf%b exp=10/ovf0", bus.count, bus.ovf); end
    bus.down = 1;
    tick();
    bus.down = 0;
    checks++; if (bus.count !== 8'd20 || bus.unf !== 1'b1) begin failures++;
      $display("FAIL wrap_down got=%0d/unf%b exp=20/unf1", bus.count, bus.unf); end
    tick();
    checks++; if (bus.unf !== 1'b0) begin failures++;
      $display("FAIL wrap_unf_pulse got=%b exp=0", bus.unf); end
  endtask

  task automatic test_saturate();
    bus.sat_mode = 1;
    do_load(8'd19);
    bus.step = 4'd3; bus.up = 1;
    tick();
    checks++; if (bus.count !== 8'd20 || bus.ovf !== 1'b1) begin failures++;
      $display("FAIL sat_up1 got=%0d/ovf%b exp=20/ovf1", bus.count, bus.ovf); end
    tick();
    checks++; if (bus.count !== 8'd20 || bus.ovf !== 1'b1 || bus.at_hi !== 1'b1) begin
      failures++;
      $display("FAIL sat_up2 got=%0d/ovf%b/at_hi%b exp=20/ovf1/at_hi1", bus.count, bus.ovf,
               bus.at_hi); end
    bus.up = 0; bus.down = 1;
    tick();
    bus.down = 0;
    checks++; if (bus.count !== 8'd17 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
      failures++;
      $display("FAIL sat_down got=%0d/%b%b exp=17/00", bus.count, bus.ovf, bus.unf); end
  endtask

  task automatic test_oneshot();
    bus.sat_mode = 0; bus.oneshot = 1;
    do_load(8'd18);
    bus.step = 4'd3; bus.up = 1;
    tick();
    checks++; if (bus.count !== 8'd10 || bus.busy !== 1'b0 || bus.ovf !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_hit got=%0d/busy%b/ovf%b exp=10/busy0/ovf1", bus.count, bus.busy,
               bus.ovf); end
    tick();
    checks++; if (bus.count !== 8'd10 || bus.ovf !== 1'b0) begin failures++;
      $display("FAIL oneshot_frozen got=%0d/ovf%b exp=10/ovf0", bus.count, bus.ovf); end
    bus.up = 0;
    do_load(8'd12);
    checks++; if (bus.count !== 8'd12 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL oneshot_rearm got=%0d/busy%b exp=12/busy1", bus.count, bus.busy); end
    bus.oneshot = 0;
  endtask

  task automatic test_hold();
    bus.step = 4'd3; bus.up = 1; bus.down = 1;
    tick();
    checks++; if (bus.count !== 8'd12 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
      failures++;
      $display("FAIL hold_updown got=%0d/%b%b exp=12/00", bus.count, bus.ovf, bus.unf); end
    bus.down = 0; bus.step = 4'd0;
    tick();
    checks++; if (bus.count !== 8'd12) begin failures++;
      $display("FAIL hold_step0 got=%0d exp=12", bus.count); end
    bus.up = 0; bus.step = 4'd1; bus.en = 0; bus.up = 1;
    tick();
    checks++; if (bus.count !== 8'd12) begin failures++;
      $display("FAIL hold_en0 got=%0d exp=12", bus.count); end
    bus.up = 0; bus.en = 1;
  endtask

  task automatic test_bound_change();
    do_load(8'd15);
    bus.hi_bound = 8'd12;
    checks++; if (bus.count !== 8'd15 || bus.at_hi !== 1'b0) begin failures++;
      $display("FAIL bound_nocorrect got=%0d/at_hi%b exp=15/at_hi0", bus.count, bus.at_hi); end
    bus.step = 4'd1; bus.up = 1;
    tick();
    bus.up = 0;
    checks++; if (bus.count !== 8'd10 || bus.ovf !== 1'b1) begin failures++;
      $display("FAIL bound_newhi got=%0d/ovf%b exp=10/ovf1", bus.count, bus.ovf); end
    bus.hi_bound = 8'd20;
  endtask

  task automatic test_edges();
    bus.lo_bound = 8'd5; bus.hi_bound = 8'd5; bus.sat_mode = 1;
    do_load(8'd5);
    bus.step = 4'd1; bus.up = 1;
    tick();
    checks++; if (bus.count !== 8'd5 || bus.ovf !== 1'b1) begin failures++;
      $display("FAIL eq_up got=%0d/ovf%b exp=5/ovf1", bus.count, bus.ovf); end
    bus.up = 0; bus.down = 1;
    tick();
    bus.down = 0;
    checks++; if (bus.count !== 8'd5 || bus.unf !== 1'b1) begin failures++;
      $display("FAIL eq_down got=%0d/unf%b exp=5/unf1", bus.count, bus.unf); end
    bus.lo_bound = 8'd0; bus.hi_bound = 8'd255;
    do_load(8'd2);
    bus.step = 4'd3; bus.down = 1;
    tick();
    checks++; if (bus.count !== 8'd0 || bus.unf !== 1'b1) begin failures++;
      $display("FAIL neg_sat got=%0d/unf%b exp=0/unf1", bus.count, bus.unf); end
    bus.sat_mode = 0;
    tick();
    bus.down = 0;
    checks++; if (bus.count !== 8'd255 || bus.unf !== 1'b1) begin failures++;
      $display("FAIL neg_wrap got=%0d/unf%b exp=255/unf1", bus.count, bus.unf); end
    bus.step = 4'd15; bus.up = 1;
    tick();
    bus.up = 0;
    checks++; if (bus.count !== 8'd0 || bus.ovf !== 1'b1) begin failures++;
      $display("FAIL top_wrap got=%0d/ovf%b exp=0/ovf1", bus.count, bus.ovf); end
  endtask

  task automatic test_load_clear();
    bus.lo_bound = 8'd10; bus.hi_bound = 8'd20;
    do_load(8'd3);
    checks++; if (bus.count !== 8'd10) begin failures++;
      $display("FAIL clamp_lo got=%0d exp=10", bus.count); end
    do_load(8'd200);
    checks++; if (bus.count !== 8'd20) begin failures++;
      $display("FAIL clamp_hi got=%0d exp=20", bus.count); end
    bus.lo_bound = 8'd0; bus.hi_bound = 8'd255;
    bus.clear = 1; bus.load = 1; bus.data_in = 8'd99;
    tick();
    bus.clear = 0; bus.load = 0;
    checks++; if (bus.count !== 8'd0) begin failures++;
      $display("FAIL clear_over_load got=%0d exp=0", bus.count); end
    bus.en = 0;
    do_load(8'd9);
    bus.en = 1;
    checks++; if (bus.count !== 8'd9) begin failures++;
      $display("FAIL load_en0 got=%0d exp=9", bus.count); end
  endtask

  task automatic test_reset_done();
    bus.lo_bound = 8'd0; bus.hi_bound = 8'd5; bus.sat_mode = 0; bus.oneshot = 1;
    do_load(8'd5);
    bus.step = 4'd1; bus.up = 1;
    tick();
    bus.up = 0;
    checks++; if (bus.count !== 8'd0 || bus.busy !== 1'b0 || bus.ovf !== 1'b1) begin
      failures++;
      $display("FAIL done_enter got=%0d/busy%b/ovf%b exp=0/busy0/ovf1", bus.count, bus.busy,
               bus.ovf); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.ovf !== 1'b0 || bus.count !== 8'd0) begin
      failures++;
      $display("FAIL reset_in_done got=%0d/busy%b/ovf%b exp=0/busy1/ovf0", bus.count,
               bus.busy, bus.ovf); end
    @(negedge clk);
    reset = 1'b0;
    bus.oneshot = 0; bus.hi_bound = 8'd255;
    tick();
    do_load(8'd40);
    bus.up = 1;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.count !== 8'd0) begin failures++;
      $display("FAIL reset_midrun got=%0d exp=0", bus.count); end
    bus.up = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

`ifdef UDC_SNAPSHOT_EN
  task automatic test_snapshot();
    bus.lo_bound = 8'd0; bus.hi_bound = 8'd255; bus.step = 4'd1;
    do_load(8'd7);
    bus.snap = 1; bus.up = 1;
    tick();
    bus.snap = 0; bus.up = 0;
    checks++; if (bus.snap_count !== 8'd7 || bus.count !== 8'd8) begin failures++;
      $display("FAIL snap_capture got=%0d/%0d exp=7/8", bus.snap_count, bus.count); end
    tick();
    checks++; if (bus.snap_count !== 8'd7) begin failures++;
      $display("FAIL snap_hold got=%0d exp=7", bus.snap_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.snap_count !== 8'd0 || bus.count !== 8'd0) begin failures++;
      $display("FAIL snap_reset got=%0d/%0d exp=0/0", bus.snap_count, bus.count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask
`else
  task automatic test_snapshot();
    bus.snap = 1;
    do_load(8'd7);
    bus.snap = 0;
    checks++; if (bus.snap_count !== 8'd0) begin failures++;
      $display("FAIL snap_disabled got=%0d exp=0", bus.snap_count); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic_up();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_hold();
    test_bound_change();
    test_edges();
    test_load_clear();
    test_reset_done();
    test_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
